// File: rtl/bram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_pkg
//  Description : Shared constants, types and helpers for the block-RAM FIFO
//                controller and its output skid buffer.
//  Contents    : ptr_w()     - RAM address width for a given depth
//                OUT_DEPTH   - number of entries in the output buffer
//                out_occ_t   - output-buffer occupancy (0..OUT_DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_fifo_pkg;

    localparam int OUT_DEPTH = 2;

    typedef logic [1:0] out_occ_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_if
//  Description : Queue-side (enq/deq/first/count) and RAM-side (write/read
//                method ports, registered read data) signals of bram_fifo.
//  Modports    : slave  - the FIFO controller
//                master - the surrounding pipeline plus the RAM
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_fifo_if
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1024
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = ptr_w(DEPTH + 2) + 1;

    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;
    logic             deq__ENA;
    logic             deq__RDY;
    logic [WIDTH-1:0] first;
    logic             first__RDY;
    logic [CW-1:0]    count;
    logic             mem_write__ENA;
    logic [AW-1:0]    mem_write_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic             mem_read__ENA;
    logic [AW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_dataOut;

    modport slave (
        input  enq__ENA, enq_v, deq__ENA, mem_dataOut,
        output enq__RDY, deq__RDY, first, first__RDY, count,
               mem_write__ENA, mem_write_addr, mem_write_data,
               mem_read__ENA, mem_read_addr
    );

    modport master (
        output enq__ENA, enq_v, deq__ENA, mem_dataOut,
        input  enq__RDY, deq__RDY, first, first__RDY, count,
               mem_write__ENA, mem_write_addr, mem_write_data,
               mem_read__ENA, mem_read_addr
    );

endinterface
`default_nettype wire

// File: rtl/bram_fifo_fifo2_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo2_skid
//  Description : Two-entry FIFO used as the output buffer behind a RAM with
//                one cycle of read latency. Push and pop may coincide at any
//                occupancy; the producer must never push into a full buffer
//                without popping in the same cycle.
//  Ports       : CLK, nRST      - clock, synchronous active-low reset
//                push_i/_data_i - write tail
//                pop_i          - remove head
//                head_o/_vld_o  - head element and its valid flag
//                occ_o          - entries held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo2_skid
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  wire logic             CLK,
    input  wire logic             nRST,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  head_vld_o,
    output out_occ_t              occ_o
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } entry_t;

    // slot0 is always the head; slot1 is only valid when slot0 is valid.
    entry_t slot0_q, slot0_d;
    entry_t slot1_q, slot1_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop_i) begin
            slot0_d = slot1_q;
            slot1_d = '0;
        end
        if (push_i) begin
            if (!slot0_d.valid) begin
                slot0_d = '{valid: 1'b1, data: push_data_i};
            end else begin
                slot1_d = '{valid: 1'b1, data: push_data_i};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign head_o     = slot0_q.data;
    assign head_vld_o = slot0_q.valid;
    assign occ_o      = out_occ_t'({1'b0, slot0_q.valid}) + out_occ_t'({1'b0, slot1_q.valid});

    a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST)
        !(push_i && !pop_i && (occ_o == out_occ_t'(OUT_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/bram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo
//  Description : FIFO controller that stores elements in an external block
//                RAM (1 write port, 1 registered read port) and hides the
//                read latency with a 2-entry output buffer, so enq and deq can
//                both fire every cycle. Capacity is DEPTH + 2.
//  Ports       : CLK  - clock
//                nRST - synchronous active-low reset
//                bus  - queue interface (enq/deq/first/count) and RAM method
//                       ports (mem_write, mem_read, mem_dataOut)
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1024
)
(
    input  wire logic  CLK,
    input  wire logic  nRST,
    bram_fifo_if.slave bus
);
    localparam int AW  = ptr_w(DEPTH);
    localparam int MCW = AW + 1;
    localparam int CW  = ptr_w(DEPTH + 2) + 1;

    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [MCW-1:0] mem_count_q, mem_count_d;
    logic [CW-1:0]  count_q, count_d;
    logic           inflight_q;
    logic           init_done_q;

    logic           enq_rdy;
    logic           enq_fire;
    logic           deq_fire;
    logic           read_issue;
    logic [2:0]     pending;
    out_occ_t       out_occ;
    logic           head_vld;
    logic [WIDTH-1:0] head;

    // The RAM ignores writes in the first cycle after reset release, so
    // pushes stay blocked until one clean edge has passed.
    assign enq_rdy  = init_done_q && (mem_count_q < MCW'(DEPTH));
    assign enq_fire = bus.enq__ENA && enq_rdy;
    assign deq_fire = bus.deq__ENA && head_vld;

    // Elements that will sit in the output buffer after this edge. A read is
    // only issued when its data is guaranteed a free slot on capture.
    assign pending    = {1'b0, out_occ} + {2'b00, inflight_q} - {2'b00, deq_fire};
    assign read_issue = (mem_count_q != '0) && (pending < 3'd2);

    always_comb begin
        wptr_d      = wptr_q + AW'(enq_fire);
        rptr_d      = rptr_q + AW'(read_issue);
        mem_count_d = mem_count_q + MCW'(enq_fire) - MCW'(read_issue);
        count_d     = count_q + CW'(enq_fire) - CW'(deq_fire);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_count_q <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_count_q <= mem_count_d;
            count_q     <= count_d;
            inflight_q  <= read_issue;
            init_done_q <= 1'b1;
        end
    end

    fifo2_skid #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .CLK         (CLK),
        .nRST        (nRST),
        .push_i      (inflight_q),
        .push_data_i (bus.mem_dataOut),
        .pop_i       (deq_fire),
        .head_o      (head),
        .head_vld_o  (head_vld),
        .occ_o       (out_occ)
    );

    assign bus.enq__RDY       = enq_rdy;
    assign bus.deq__RDY       = head_vld;
    assign bus.first          = head;
    assign bus.first__RDY     = head_vld;
    assign bus.count          = count_q;
    assign bus.mem_write__ENA = enq_fire;
    assign bus.mem_write_addr = wptr_q;
    assign bus.mem_write_data = bus.enq_v;
    assign bus.mem_read__ENA  = read_issue;
    assign bus.mem_read_addr  = rptr_q;

    a_deq_when_empty: assert property (@(posedge CLK) disable iff (!nRST)
        !(bus.deq__ENA && !head_vld));

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_fifo
//  Description : Directed and randomised bench for bram_fifo with a behavioural
//                registered-read RAM attached to the memory ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 2) + 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    bram_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] ram_q;

    always @(posedge CLK) begin
        if (bus.mem_write__ENA) ram[bus.mem_write_addr] <= bus.mem_write_data;
        if (bus.mem_read__ENA)  ram_q <= ram[bus.mem_read_addr];
    end
    assign bus.mem_dataOut = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pop until n_exp elements came out (bounded); expects first_val, +step, ...
    task automatic drain(input string tag, input int n_exp,
                         input logic [3:0] first_val, input logic [3:0] step);
        int         got  = 0;
        int         errs = 0;
        logic [3:0] e    = first_val;
        for (int cyc = 0; cyc < 1200 && got < n_exp; cyc++) begin
            bus.deq__ENA = bus.deq__RDY;
            if (bus.deq__RDY) begin
                if (bus.first !== e) errs++;
                e = e + step;
                got++;
            end
            tick();
        end
        bus.deq__ENA = 1'b0;
        #1;
        check({tag, "_n"}, got, n_exp);
        check({tag, "_data"}, errs, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_empty"}, bus.first__RDY, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int         data_errs, bubbles, cnt_errs, addr_errs, rdy_errs, ndeq, nacc, stale, rerr;
        logic [3:0] eo;
        logic [3:0] q [$];

        bus.enq__ENA = 1'b0;
        bus.enq_v    = '0;
        bus.deq__ENA = 1'b0;

        // ---------------- reset ----------------
        nRST = 1'b0;
        tick();
        tick();
        #1;
        check("rst_count", bus.count, 0);
        check("rst_first_rdy", bus.first__RDY, 0);
        check("rst_deq_rdy", bus.deq__RDY, 0);
        check("rst_wr_ena", bus.mem_write__ENA, 0);
        check("rst_rd_ena", bus.mem_read__ENA, 0);

        // ---------------- init cycle + first latency ----------------
        nRST = 1'b1;
        bus.enq__ENA = 1'b1;
        bus.enq_v    = 4'hA;
        #1;
        check("c0_enq_rdy", bus.enq__RDY, 0);
        check("c0_wr_ena", bus.mem_write__ENA, 0);
        tick();
        check("c1_enq_rdy", bus.enq__RDY, 1);
        check("c1_wr_ena", bus.mem_write__ENA, 1);
        check("c1_wr_addr", bus.mem_write_addr, 0);
        tick();
        check("c2_first_rdy", bus.first__RDY, 0);
        tick();
        check("c3_first_rdy", bus.first__RDY, 0);
        tick();
        bus.enq__ENA = 1'b0;
        #1;
        check("c4_first_rdy", bus.first__RDY, 1);
        check("c4_first", bus.first, 4'hA);
        check("c4_count", bus.count, 3);
        drain("t1", 3, 4'hA, 4'h0);

        // ---------------- 1,2,3,4 then drain ----------------
        for (int i = 0; i < 4; i++) begin
            bus.enq__ENA = 1'b1;
            bus.enq_v    = 4'(i + 1);
            tick();
        end
        bus.enq__ENA = 1'b0;
        repeat (4) tick();
        check("seq_count_full", bus.count, 4);
        check("seq_first_rdy", bus.first__RDY, 1);
        for (int i = 0; i < 4; i++) begin
            bus.deq__ENA = 1'b1;
            #1;
            check($sformatf("seq_first%0d", i), bus.first, i + 1);
            check($sformatf("seq_count%0d", i), bus.count, 4 - i);
            tick();
        end
        bus.deq__ENA = 1'b0;
        #1;
        check("seq_empty", bus.first__RDY, 0);
        check("seq_count_end", bus.count, 0);

        // ---------------- streaming enq+deq, pointer wrap ----------------
        // Seven elements were written so far, so wptr starts at 7.
        data_errs = 0; bubbles = 0; cnt_errs = 0; addr_errs = 0; rdy_errs = 0;
        ndeq = 0; eo = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            bus.enq__ENA = 1'b1;
            bus.enq_v    = 4'(i);
            bus.deq__ENA = bus.deq__RDY;
            #1;
            if (bus.enq__RDY !== 1'b1) rdy_errs++;
            if (bus.mem_write_addr !== AW'((7 + i) % DEPTH)) addr_errs++;
            if (bus.deq__RDY) begin
                if (bus.first !== eo) data_errs++;
                eo = eo + 4'h1;
                ndeq++;
            end else if (i >= 3) begin
                bubbles++;
            end
            if (i >= 3 && bus.count !== CW'(3)) cnt_errs++;
            tick();
        end
        bus.enq__ENA = 1'b0;
        bus.deq__ENA = 1'b0;
        check("stream_data", data_errs, 0);
        check("stream_bubbles", bubbles, 0);
        check("stream_count", cnt_errs, 0);
        check("stream_addr", addr_errs, 0);
        check("stream_enq_rdy", rdy_errs, 0);
        check("stream_ndeq", ndeq, 2997);
        drain("t3", 3, 4'd5, 4'h1);

        // ---------------- fill to capacity ----------------
        nacc = 0;
        for (int j = 0; j < 1100; j++) begin
            bus.enq__ENA = 1'b1;
            bus.enq_v    = 4'(j);
            #1;
            if (!bus.enq__RDY) break;
            nacc++;
            tick();
        end
        bus.enq__ENA = 1'b0;
        #1;
        check("fill_accepted", nacc, DEPTH + 2);
        check("fill_count", bus.count, DEPTH + 2);
        check("fill_enq_rdy", bus.enq__RDY, 0);
        bus.deq__ENA = 1'b1;
        #1;
        check("fill_first", bus.first, 0);
        tick();
        bus.deq__ENA = 1'b0;
        #1;
        check("fill_rdy_back", bus.enq__RDY, 1);
        check("fill_count_dec", bus.count, DEPTH + 1);
        bus.enq__ENA = 1'b1;
        bus.enq_v    = 4'(DEPTH + 2);
        tick();
        bus.enq__ENA = 1'b0;
        drain("t4", DEPTH + 2, 4'd1, 4'h1);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 6; i++) begin
            bus.enq__ENA = 1'b1;
            bus.enq_v    = 4'(8 + i);
            tick();
        end
        bus.enq__ENA = 1'b0;
        repeat (3) tick();
        bus.deq__ENA = 1'b1;
        tick();
        bus.deq__ENA = 1'b0;
        #1;
        check("mid_count", bus.count, 5);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        #1;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_first_rdy", bus.first__RDY, 0);
        check("mid_rst_enq_rdy", bus.enq__RDY, 0);
        stale = 0;
        repeat (5) begin
            tick();
            if (bus.first__RDY !== 1'b0) stale++;
        end
        check("mid_stale", stale, 0);
        bus.enq__ENA = 1'b1;
        bus.enq_v    = 4'h3;
        tick();
        bus.enq__ENA = 1'b0;
        drain("t5", 1, 4'h3, 4'h0);

        // ---------------- randomised traffic vs queue model ----------------
        rerr = 0;
        q.delete();
        for (int k = 0; k < 400; k++) begin
            bus.enq__ENA = bus.enq__RDY && ($urandom_range(0, 3) != 0);
            bus.enq_v    = 4'($urandom);
            bus.deq__ENA = bus.deq__RDY && ($urandom_range(0, 2) != 0);
            #1;
            if (bus.count !== CW'(q.size())) rerr++;
            if (bus.deq__RDY) begin
                if (q.size() == 0) rerr++;
                else if (bus.first !== q[0]) rerr++;
            end
            if (bus.enq__ENA) q.push_back(bus.enq_v);
            if (bus.deq__ENA && q.size() != 0) void'(q.pop_front());
            tick();
        end
        bus.enq__ENA = 1'b0;
        bus.deq__ENA = 1'b0;
        check("rand_errs", rerr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
